// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control
// Description : Multicycle control FSM for a load/store/R/I-type MIPS
//               datapath. Accepts instructions via valid/ready, latches them
//               into an IR, sequences FETCH/DECODE/EXEC/MEM/WB and produces
//               registered datapath control strobes plus a retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic [31:0]      instruction,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [31:0]      ir_out,
  output logic [3:0]       ALU_OP,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic             RegDst,
  output logic             pc_en,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] KIND_ALU = 2'd0;
  localparam logic [1:0] KIND_LW  = 2'd1;
  localparam logic [1:0] KIND_SW  = 2'd2;
  localparam logic [1:0] KIND_ILL = 2'd3;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  // Decoded bundle layout: {kind[1:0], alu_op[3:0], alusrc, regdst}
  function automatic logic [7:0] decode(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] funct;
    logic [7:0] d;
    op    = ins[31:26];
    funct = ins[5:0];
    d     = {KIND_ILL, 4'b0000, 1'b0, 1'b0};
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: d = {KIND_ALU, OP_ADD, 1'b0, 1'b1};
          6'b100010: d = {KIND_ALU, OP_SUB, 1'b0, 1'b1};
          6'b100100: d = {KIND_ALU, OP_AND, 1'b0, 1'b1};
          6'b100101: d = {KIND_ALU, OP_OR,  1'b0, 1'b1};
          6'b101010: d = {KIND_ALU, OP_SLT, 1'b0, 1'b1};
          default:   d = {KIND_ILL, 4'b0000, 1'b0, 1'b0};
        endcase
      end
      6'b001000: d = {KIND_ALU, OP_ADD, 1'b1, 1'b0};
      6'b001100: d = {KIND_ALU, OP_AND, 1'b1, 1'b0};
      6'b001101: d = {KIND_ALU, OP_OR,  1'b1, 1'b0};
      6'b100011: d = {KIND_LW,  OP_ADD, 1'b1, 1'b0};
      6'b101011: d = {KIND_SW,  OP_ADD, 1'b1, 1'b0};
      default:   d = {KIND_ILL, 4'b0000, 1'b0, 1'b0};
    endcase
    return d;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic               regwrite_q, regwrite_d;
  logic               memread_q, memread_d;
  logic               memwrite_q, memwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic               alusrc_q, alusrc_d;
  logic               regdst_q, regdst_d;
  logic               pc_en_q, pc_en_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [7:0]         ir_dec;
  logic [7:0]         in_dec;
  logic [1:0]         kind;
  logic               accept;
  logic               hold;

  // Decode of the latched IR (stable from DECODE through retirement) and of
  // the incoming word, so the illegal pulse can land in the DECODE cycle.
  always_comb begin
    ir_dec = decode(ir_q);
    in_dec = decode(instruction);
    kind   = ir_dec[7:6];
    accept = (state_q == S_FETCH) && instr_valid;
  end

  // Next-state and next-output logic; every output is computed against the
  // upcoming state so the registered strobes line up with that state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = (kind == KIND_ILL) ? S_FETCH : S_EXEC;
      S_EXEC:   state_d = (kind == KIND_LW || kind == KIND_SW) ? S_MEM : S_WB;
      S_MEM:    state_d = (kind == KIND_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase

    ir_d       = accept ? instruction : ir_q;
    illegal_d  = accept && (in_dec[7:6] == KIND_ILL);
    hold       = (state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB);
    alu_op_d   = hold ? ir_dec[5:2] : 4'b0000;
    alusrc_d   = hold && ir_dec[1];
    regdst_d   = hold && ir_dec[0];
    memtoreg_d = hold && (kind == KIND_LW);
    regwrite_d = (state_d == S_WB);
    memread_d  = (kind == KIND_LW) && ((state_d == S_MEM) || (state_d == S_WB));
    memwrite_d = (kind == KIND_SW) && (state_d == S_MEM);
    pc_en_d    = regwrite_d || memwrite_d;
    retired_d  = retired_q + CNT_W'(pc_en_d);
  end

  // State and output registers, cleared immediately on reset assertion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      ir_q       <= 32'd0;
      alu_op_q   <= 4'b0000;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      pc_en_q    <= 1'b0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      alu_op_q   <= alu_op_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      regdst_q   <= regdst_d;
      pc_en_q    <= pc_en_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
    end
  end

  assign instr_ready = (state_q == S_FETCH);
  assign busy        = (state_q != S_FETCH);
  assign ir_out      = ir_q;
  assign ALU_OP      = alu_op_q;
  assign RegWrite    = regwrite_q;
  assign MemRead     = memread_q;
  assign MemWrite    = memwrite_q;
  assign MemtoReg    = memtoreg_q;
  assign ALUSrc      = alusrc_q;
  assign RegDst      = regdst_q;
  assign pc_en       = pc_en_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_control
// Description : Table-driven bench for mips_multicycle_control with
//               cycle-by-cycle expected output bundles, plus hand sequences
//               for mid-instruction reset and back-to-back counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

  localparam int CNT_W = 2;

  localparam logic [1:0] K_ALU = 2'd0;
  localparam logic [1:0] K_LW  = 2'd1;
  localparam logic [1:0] K_SW  = 2'd2;
  localparam logic [1:0] K_ILL = 2'd3;

  logic             clk;
  logic             rst;
  logic [31:0]      instruction;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      ir_out;
  logic [3:0]       ALU_OP;
  logic             RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst;
  logic             pc_en, busy, illegal;
  logic [CNT_W-1:0] retired;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_ret;

  mips_multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ir_out      (ir_out),
    .ALU_OP      (ALU_OP),
    .RegWrite    (RegWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .ALUSrc      (ALUSrc),
    .RegDst      (RegDst),
    .pc_en       (pc_en),
    .busy        (busy),
    .illegal     (illegal),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [1:0]  kind;
    logic [3:0]  alu;
    logic        src;
    logic        dst;
  } vec_t;

  // Bundle: {ready, busy, alu[3:0], rw, mr, mw, m2r, src, dst, pc, ill, ret[1:0]}
  function automatic logic [15:0] pack(input logic rdy, input logic bsy,
                                       input logic [3:0] alu, input logic rw,
                                       input logic mr, input logic mw,
                                       input logic m2r, input logic src,
                                       input logic dst, input logic pc,
                                       input logic ill, input logic [1:0] ret);
    return {rdy, bsy, alu, rw, mr, mw, m2r, src, dst, pc, ill, ret};
  endfunction

  function automatic logic [15:0] actual();
    return {instr_ready, busy, ALU_OP, RegWrite, MemRead, MemWrite, MemtoReg,
            ALUSrc, RegDst, pc_en, illegal, retired};
  endfunction

  task automatic chk(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (rdy,busy,alu,rw,mr,mw,m2r,src,dst,pc,ill,ret)",
               name, act, exp);
    end
  endtask

  task automatic chk_ir(input string name, input logic [31:0] exp);
    checks++;
    if (ir_out !== exp) begin
      errors++;
      $display("FAIL %s: ir_out got %h expected %h", name, ir_out, exp);
    end
  endtask

  // Called at a negedge with the controller in FETCH; returns at the negedge
  // of the cycle following the last busy cycle (FETCH again).
  task automatic run_one(input vec_t v);
    logic m2r;
    m2r = (v.kind == K_LW);
    instruction = v.instr;
    instr_valid = 1'b1;
    chk({v.name, ".c1"}, pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
    @(negedge clk);
    instr_valid = 1'b0;
    instruction = 32'hDEAD_BEEF;
    chk({v.name, ".c2"}, pack(0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, v.kind == K_ILL, exp_ret));
    chk_ir({v.name, ".ir"}, v.instr);
    @(negedge clk);
    if (v.kind == K_ILL) begin
      chk({v.name, ".c3"}, pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
      return;
    end
    chk({v.name, ".c3"}, pack(0, 1, v.alu, 0, 0, 0, m2r, v.src, v.dst, 0, 0, exp_ret));
    @(negedge clk);
    case (v.kind)
      K_LW:  chk({v.name, ".c4"}, pack(0, 1, v.alu, 0, 1, 0, 1, v.src, v.dst, 0, 0, exp_ret));
      K_SW: begin
        exp_ret = exp_ret + 2'd1;
        chk({v.name, ".c4"}, pack(0, 1, v.alu, 0, 0, 1, 0, v.src, v.dst, 1, 0, exp_ret));
      end
      default: begin
        exp_ret = exp_ret + 2'd1;
        chk({v.name, ".c4"}, pack(0, 1, v.alu, 1, 0, 0, 0, v.src, v.dst, 1, 0, exp_ret));
      end
    endcase
    @(negedge clk);
    if (v.kind == K_LW) begin
      exp_ret = exp_ret + 2'd1;
      chk({v.name, ".c5"}, pack(0, 1, v.alu, 1, 1, 0, 1, v.src, v.dst, 1, 0, exp_ret));
      @(negedge clk);
    end
    chk({v.name, ".idle"}, pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{"add",   32'h0002_8020, K_ALU, 4'b0010, 1'b0, 1'b1};
    tbl[1]  = '{"lw",    32'h8C41_0001, K_LW,  4'b0010, 1'b1, 1'b0};
    tbl[2]  = '{"sw",    32'hACA5_0002, K_SW,  4'b0010, 1'b1, 1'b0};
    tbl[3]  = '{"sub",   32'h0128_A822, K_ALU, 4'b0110, 1'b0, 1'b1};
    tbl[4]  = '{"ori",   32'h3517_0000, K_ALU, 4'b0001, 1'b1, 1'b0};
    tbl[5]  = '{"ill",   32'hFC00_0000, K_ILL, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{"and",   32'h0109_4024, K_ALU, 4'b0000, 1'b0, 1'b1};
    tbl[7]  = '{"or",    32'h0109_4025, K_ALU, 4'b0001, 1'b0, 1'b1};
    tbl[8]  = '{"slt",   32'h0109_402A, K_ALU, 4'b0111, 1'b0, 1'b1};
    tbl[9]  = '{"addi",  32'h2001_0005, K_ALU, 4'b0010, 1'b1, 1'b0};
    tbl[10] = '{"andi",  32'h3001_000F, K_ALU, 4'b0000, 1'b1, 1'b0};
    tbl[11] = '{"illfn", 32'h0000_0021, K_ILL, 4'b0000, 1'b0, 1'b0};

    rst         = 1'b0;
    instr_valid = 1'b0;
    instruction = 32'd0;
    exp_ret     = '0;
    repeat (2) @(negedge clk);
    chk("reset", pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    chk_ir("reset.ir", 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_one(tbl[i]);

    // Reset asserted while an lw sits in MEM.
    instruction = 32'h8C41_0001;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.mem", pack(0, 1, 4'b0010, 0, 1, 0, 1, 1, 0, 0, 0, exp_ret));
    rst = 1'b0;
    #1;
    exp_ret = '0;
    chk("rst.async", pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    @(negedge clk);
    chk("rst.held", pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    chk_ir("rst.ir", 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle", pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    end

    // Back-to-back addi with valid held high: retired 1,2,3,0,1.
    instruction = 32'h2001_0005;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("b2b.fetch", pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
      @(negedge clk);
      chk("b2b.dec", pack(0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
      @(negedge clk);
      chk("b2b.exec", pack(0, 1, 4'b0010, 0, 0, 0, 0, 1, 0, 0, 0, exp_ret));
      @(negedge clk);
      exp_ret = exp_ret + 2'd1;
      chk("b2b.wb", pack(0, 1, 4'b0010, 1, 0, 0, 0, 1, 0, 1, 0, exp_ret));
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("b2b.end", pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1));
    @(negedge clk);
    chk("b2b.idle", pack(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle control FSM that sits directly upstream of the load/store/R/I-type datapath and drives its control inputs (ALU_OP, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst).
- Accepts a 32-bit instruction from instruction fetch via a valid/ready handshake and latches it into an internal IR.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and pulses pc_en at retirement so fetch advances exactly once per instruction.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- instruction  input  32  instruction word from fetch.
- instr_valid  input  1  instruction word valid.
- instr_ready  output  1  controller accepts instruction this cycle.
- ir_out  output  32  latched instruction; feeds the datapath instruction input.
- ALU_OP  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- RegWrite  output  1  register file write strobe.
- MemRead  output  1  data memory read enable.
- MemWrite  output  1  data memory write strobe.
- MemtoReg  output  1  1 selects memory data for writeback.
- ALUSrc  output  1  1 selects sign-extended immediate.
- RegDst  output  1  1 selects rd [15:11]; 0 selects rt [20:16].
- pc_en  output  1  one-cycle pulse at retirement.
- busy  output  1  high in any state other than FETCH.
- illegal  output  1  one-cycle pulse on an undecodable instruction.
- retired  output  CNT_W  count of retired legal instructions; wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to FETCH.
  - ir_out, retired and all control outputs go to 0.
  - Takes effect immediately, including mid-instruction. No strobe may glitch high during or after reset.
- FETCH:
  - instr_ready = 1.
  - instr_valid = 1: latch IR, go to DECODE.
  - instr_valid = 0: stay in FETCH. All strobes stay 0.
- DECODE: register the decoded controls from IR. Legal instructions go to EXEC.
- Decode table (op = IR[31:26], funct = IR[5:0]):
  - op 000000: funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. RegDst=1, ALUSrc=0.
  - 001000 addi/ADD, 001100 andi/AND, 001101 ori/OR: RegDst=0, ALUSrc=1.
  - 100011 lw and 101011 sw: ALU_OP=ADD, ALUSrc=1.
  - Anything else is illegal: pulse illegal, go to FETCH. No RegWrite, MemWrite or pc_en; retired unchanged.
- Control holding: ALU_OP, ALUSrc, RegDst and MemtoReg are driven from DECODE+1 through retirement, held stable, and return to 0 in FETCH.
- EXEC (datapath ALU settles):
  - R/I-type: go to WB.
  - lw/sw: go to MEM.
- MEM:
  - lw: MemRead = 1, go to WB.
  - sw: MemWrite = 1 for exactly this cycle; retires here, go to FETCH.
- WB:
  - RegWrite = 1 for exactly this cycle.
  - lw: MemRead = 1 and MemtoReg = 1 also held.
  - Go to FETCH.
- Retirement cycle (sw MEM, all WB): pc_en = 1 and retired increments, both in that cycle only.
- Latency, cycles from instr_valid acceptance to retirement inclusive: R/I-type 4, sw 4, lw 5, illegal 2 (no retirement).
- Exclusivity:
  - RegWrite and MemWrite are never high in the same cycle.
  - At most one RegWrite/MemWrite strobe per instruction.
- Counter wrap: retired wraps from 2^CNT_W−1 to 0 without side effects.
- Outputs are registered; only instr_ready and busy are decoded from state.

Test Plan:
- Reset then idle: rst=0 mid-lw MEM state -> next cycle state FETCH, MemRead=0, RegWrite=0, retired=0. rst=1 with instr_valid=0 for 5 cycles -> instr_ready=1, no strobes.
- R-type: instruction 0x00028020 (add R16,R0,R2) -> RegWrite exactly 4 cycles after acceptance with ALU_OP=0010, RegDst=1, ALUSrc=0. pc_en coincides; retired=1.
- lw: instruction 0x8C410001 (lw R1,1(R2)) -> MemRead in cycles 4–5, MemtoReg=1, RegWrite only in cycle 5, ALUSrc=1, RegDst=0.
- sw: instruction 0xACA50002 -> single MemWrite pulse in cycle 4, RegWrite never asserted, pc_en in cycle 4.
- sub, ori and illegal:
  - 0x0128A822 -> ALU_OP=0110.
  - 0x35170000 -> ALU_OP=0001, ALUSrc=1.
  - 0xFC000000 -> illegal pulse in cycle 2, no pc_en, retired unchanged, back in FETCH.
- Back-to-back and wrap: CNT_W=2, instr_valid held high with 5 addi -> retired sequence 1,2,3,0,1. The next instruction is accepted the cycle after each pc_en.
